// File: rtl/dmem_pkg.sv
// Shared definitions for sized_data_memory.
// Contents:
//   size_e           - access size encodings carried on req_size
//   state_e          - request sequencing FSM states
//   CNT_W            - width of the latency countdown
//   size_addr_error  - alignment / reserved-size check for one access
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_B    = 2'b00,
    SIZE_H    = 2'b01,
    SIZE_W    = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StWait = 1'b1
  } state_e;

  // Holds LATENCY-1, and LATENCY never exceeds 4.
  localparam int unsigned CNT_W = 2;

  // Misaligned half/word accesses and the reserved size are rejected.
  function automatic logic size_addr_error(input size_e size, input logic [1:0] addr_lo);
    logic err;
    case (size)
      SIZE_B:  err = 1'b0;
      SIZE_H:  err = addr_lo[0];
      SIZE_W:  err = |addr_lo;
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/sized_data_memory_if.sv
// Request/response bus of sized_data_memory.
// Parameters: ADDR_W - byte address width.
// Signals:
//   req_valid/req_ready          - request handshake
//   req_write, req_size,
//   req_unsigned, req_addr,
//   req_wdata                    - request fields (store data right-aligned)
//   resp_valid                   - one-cycle response pulse
//   resp_rdata, resp_error       - extended load data / rejection flag
// Modports: master drives requests, slave (the memory) answers them.
interface sized_data_memory_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_error;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for sized_data_memory.
// Ports:
//   i_size, i_unsigned, i_addr_lo - access description
//   i_wdata                       - right-aligned store data
//   i_rword                       - raw 32-bit word read from the array
//   o_be                          - per-lane write enables (lane 0 = bits [7:0])
//   o_wdata                       - store data replicated onto every candidate lane
//   o_rdata                       - selected byte/half, sign- or zero-extended
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e       i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

  always_comb begin
    o_be    = 4'b0000;
    o_wdata = 32'h0;
    o_rdata = 32'h0;
    case (i_size)
      SIZE_B: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      end
      SIZE_H: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{~i_unsigned & w_half[15]}}, w_half};
      end
      SIZE_W: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sized_data_memory.sv
// Byte/half/word addressable data memory with a fixed request-to-response latency.
// Parameters: DEPTH_WORDS (array size in 32-bit words), ADDR_W (byte address width),
//             LATENCY (1..4 cycles from accept to response).
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset (array contents are not reset)
//   bus   - slave side of sized_data_memory_if
// One request is in flight at a time. The array is read and written on the "fire" edge,
// the edge ending cycle N+LATENCY-1, and the response is registered on that same edge.
module sized_data_memory
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned LATENCY     = 1
) (
  input logic               clk,
  input logic               rst_n,
  sized_data_memory_if.slave bus
);

  localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // With LATENCY 1 the fire edge is the accept edge, so live inputs are used directly.
  localparam bit          DIRECT = (LATENCY == 1);

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("sized_data_memory: LATENCY must be in 1..4");
  end

  state_e            r_state, w_state_d;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_accept, w_fire;

  logic              r_write, r_unsigned;
  size_e             r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic              w_write, w_unsigned;
  size_e             w_size;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;

  logic [ADDR_W-3:0] w_word_idx;
  logic              w_oob, w_err, w_mem_we;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata_sh, w_rword, w_rdata_ext;

  logic [31:0]       r_mem [DEPTH_WORDS];

  logic              r_resp_valid, r_resp_error;
  logic [31:0]       r_resp_rdata;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  // FSM: next state
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (w_accept && !DIRECT) w_state_d = StWait;
      StWait:  if (w_fire) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // FSM: outputs. rst_n gating keeps a reset edge from accepting or committing anything.
  always_comb begin
    bus.req_ready = (r_state == StIdle);
    w_accept      = rst_n && bus.req_valid && (r_state == StIdle);
    w_fire        = DIRECT ? w_accept
                           : (rst_n && (r_state == StWait) && (r_cnt == CNT_W'(1)));
  end

  // Counts down the WAIT cycles; fires when it reaches 1.
  always_ff @(posedge clk) begin
    if (!rst_n)                  r_cnt <= '0;
    else if (w_accept)           r_cnt <= CNT_W'(LATENCY - 1);
    else if (r_state == StWait)  r_cnt <= r_cnt - 1'b1;
  end

  // Request capture; later input changes are ignored until the next accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write    <= bus.req_write;
      r_size     <= size_e'(bus.req_size);
      r_unsigned <= bus.req_unsigned;
      r_addr     <= bus.req_addr;
      r_wdata    <= bus.req_wdata;
    end
  end

  assign w_write    = DIRECT ? bus.req_write            : r_write;
  assign w_size     = DIRECT ? size_e'(bus.req_size)    : r_size;
  assign w_unsigned = DIRECT ? bus.req_unsigned         : r_unsigned;
  assign w_addr     = DIRECT ? bus.req_addr             : r_addr;
  assign w_wdata    = DIRECT ? bus.req_wdata            : r_wdata;

  assign w_word_idx = w_addr[ADDR_W-1:2];
  assign w_oob      = ({1'b0, w_word_idx} >= (ADDR_W-1)'(DEPTH_WORDS));
  assign w_err      = size_addr_error(w_size, w_addr[1:0]) || w_oob;
  assign w_mem_we   = w_fire && w_write && !w_err;
  assign w_rword    = r_mem[w_word_idx[IDX_W-1:0]];

  dmem_lane_align u_lane_align (
    .i_size     (w_size),
    .i_unsigned (w_unsigned),
    .i_addr_lo  (w_addr[1:0]),
    .i_wdata    (w_wdata),
    .i_rword    (w_rword),
    .o_be       (w_be),
    .o_wdata    (w_wdata_sh),
    .o_rdata    (w_rdata_ext)
  );

  // Single 32-bit array with byte-lane write enables; no reset on contents.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int l = 0; l < 4; l++) begin
        if (w_be[l]) r_mem[w_word_idx[IDX_W-1:0]][8*l +: 8] <= w_wdata_sh[8*l +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_resp_rdata <= 32'h0;
    end else begin
      r_resp_valid <= w_fire;
      if (w_fire) begin
        r_resp_error <= w_err;
        r_resp_rdata <= (w_err || w_write) ? 32'h0 : w_rdata_ext;
      end
    end
  end

  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_error = r_resp_error;
  assign bus.resp_rdata = r_resp_rdata;

endmodule
